// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : Multicycle fetch/decode/execute/memory/write-back sequencer that
//            drives every datapath strobe of the 8-bit/16-bit-instruction CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_unit_pkg;
  localparam int ALU_OP_W = 3;

  typedef struct packed {
    logic                PC_write;
    logic                PC_sel;
    logic [1:0]          ADDER_sel;
    logic                IR_load;
    logic                AB_load;
    logic                REG2_sel;
    logic                RF_write;
    logic                REGW_sel;
    logic                ALU_sel;
    logic [ALU_OP_W-1:0] ALU_op;
    logic                ACC_load;
    logic                FLAGS_load;
    logic                MAR_load;
    logic                MDR_load;
    logic                MEM_write;
  } ctrl_sig_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;
endpackage

module control_unit
  import control_unit_pkg::*;
#(
  parameter int INSTR_WIDTH  = 16,
  parameter int ALU_OP_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [INSTR_WIDTH-1:0] instruct,
  input  alu_flags_t             flags,
  output ctrl_sig_t              sigs,
  output logic                   halted,
  output logic                   illegal
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BR   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JR   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PASSB = ALU_OP_WIDTH'(5);

  // FETCH_WAIT must encode as zero: it is both the reset and idle state.
  typedef enum logic [3:0] {
    S_FETCH_WAIT = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_WB         = 4'd4,
    S_ADDR       = 4'd5,
    S_MEM_RD     = 4'd6,
    S_MEM_WB     = 4'd7,
    S_ST_DATA    = 4'd8,
    S_ST_WR      = 4'd9,
    S_BRANCH     = 4'd10,
    S_HALT       = 4'd11
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [3:0]              opcode;
  logic [3:0]              cond;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic                    br_take;
  logic                    unused_instr_bits;

  assign opcode            = instruct[3:0];
  assign cond              = instruct[7:4];
  assign unused_instr_bits = ^instruct[INSTR_WIDTH-1:8];

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (cond)
      4'd0:    br_take = 1'b1;
      4'd1:    br_take = flags.z;
      4'd2:    br_take = ~flags.z;
      4'd3:    br_take = flags.n;
      4'd4:    br_take = flags.c;
      4'd5:    br_take = flags.v;
      default: br_take = 1'b0;
    endcase
  end

  // Outputs are a pure function of the state register plus decode, so an
  // asynchronous reset to FETCH_WAIT silences every strobe at once.
  always_comb begin
    state_d = state_q;
    sigs    = '0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_FETCH_WAIT: state_d = S_FETCH;
      S_FETCH: begin
        sigs.IR_load  = 1'b1;
        sigs.PC_write = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        sigs.AB_load = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: state_d = S_EXEC;
          OP_LD, OP_ST:                                   state_d = S_ADDR;
          OP_BR, OP_JMP, OP_JR:                           state_d = S_BRANCH;
          OP_HALT:                                        state_d = S_HALT;
          OP_NOP:                                         state_d = S_FETCH_WAIT;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH_WAIT;
          end
        endcase
      end
      S_EXEC: begin
        sigs.ALU_op     = alu_op;
        sigs.ALU_sel    = (opcode == OP_ADDI);
        sigs.ACC_load   = 1'b1;
        sigs.FLAGS_load = 1'b1;
        state_d         = S_WB;
      end
      S_WB: begin
        sigs.RF_write = 1'b1;
        state_d       = S_FETCH_WAIT;
      end
      S_ADDR: begin
        sigs.MAR_load = 1'b1;
        state_d       = (opcode == OP_LD) ? S_MEM_RD : S_ST_DATA;
      end
      S_MEM_RD: begin
        sigs.MDR_load = 1'b1;
        state_d       = S_MEM_WB;
      end
      S_MEM_WB: begin
        sigs.RF_write = 1'b1;
        sigs.REGW_sel = 1'b1;
        state_d       = S_FETCH_WAIT;
      end
      S_ST_DATA: begin
        sigs.AB_load  = 1'b1;
        sigs.REG2_sel = 1'b1;
        state_d       = S_ST_WR;
      end
      S_ST_WR: begin
        sigs.ALU_op    = ALU_PASSB;
        sigs.MEM_write = 1'b1;
        state_d        = S_FETCH_WAIT;
      end
      S_BRANCH: begin
        case (opcode)
          OP_JMP: begin
            sigs.PC_write  = 1'b1;
            sigs.ADDER_sel = 2'd2;
          end
          OP_JR: begin
            sigs.PC_write = 1'b1;
            sigs.PC_sel   = 1'b1;
          end
          default: begin
            sigs.PC_write  = br_take;
            sigs.ADDER_sel = 2'd1;
          end
        endcase
        state_d = S_FETCH_WAIT;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Directed program run through control_unit with a small datapath
//            model; per-cycle strobes are checked against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;
  import control_unit_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [15:0] ir = 16'h0000;
  alu_flags_t dp_flags = '0;
  ctrl_sig_t  sigs;
  logic       halted;
  logic       illegal;

  always #5 clk = ~clk;

  control_unit #(.INSTR_WIDTH(16), .ALU_OP_WIDTH(3)) dut (
    .clk(clk), .resetn(resetn), .instruct(ir), .flags(dp_flags),
    .sigs(sigs), .halted(halted), .illegal(illegal)
  );

  typedef struct {
    string     tag;
    ctrl_sig_t s;
    logic      h;
    logic      il;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  // Datapath model owned by the stimulus process.
  logic [15:0] rom [logic [15:0]];
  logic [7:0]  mem [logic [15:0]];
  logic [7:0]  rf [16];
  logic [15:0] pc = 16'h0000;
  logic [15:0] mar = 16'h0000;
  logic [7:0]  reg_a = 8'h00, reg_b = 8'h00, acc = 8'h00, mdr = 8'h00;

  function automatic logic [15:0] rom_rd(input logic [15:0] a);
    return rom.exists(a) ? rom[a] : 16'h0000;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input ctrl_sig_t s, input logic h = 1'b0,
                      input logic il = 1'b0);
    exp_t e;
    e.tag = tag; e.s = s; e.h = h; e.il = il;
    sbq.push_back(e);
  endtask

  task automatic dp_apply(input ctrl_sig_t s);
    logic [7:0]  b, rf_wd;
    logic [8:0]  r;
    logic [15:0] add;
    logic [15:0] pc_n, ir_n, mar_n;
    logic [7:0]  a_n, b_n, mdr_n;
    b = s.ALU_sel ? {{4{ir[15]}}, ir[15:12]} : reg_b;
    case (s.ALU_op)
      3'd0:    r = {1'b0, reg_a} + {1'b0, b};
      3'd1:    r = {1'b0, reg_a} - {1'b0, b};
      3'd2:    r = {1'b0, reg_a & b};
      3'd3:    r = {1'b0, reg_a | b};
      3'd4:    r = {1'b0, reg_a ^ b};
      3'd5:    r = {1'b0, b};
      default: r = 9'h000;
    endcase
    case (s.ADDER_sel)
      2'd1:    add = {{8{ir[15]}}, ir[15:8]};
      2'd2:    add = {{4{ir[15]}}, ir[15:4]};
      default: add = 16'd2;
    endcase
    pc_n  = s.PC_write ? (s.PC_sel ? {reg_a, reg_b} : pc + add) : pc;
    ir_n  = s.IR_load ? rom_rd(pc) : ir;
    a_n   = s.AB_load ? rf[ir[15:12]] : reg_a;
    b_n   = s.AB_load ? rf[s.REG2_sel ? ir[7:4] : ir[11:8]] : reg_b;
    mar_n = s.MAR_load ? {reg_a, reg_b} : mar;
    mdr_n = s.MDR_load ? mem_rd(mar) : mdr;
    rf_wd = s.REGW_sel ? mdr : acc;
    if (s.MEM_write) mem[mar] = r[7:0];
    if (s.RF_write) rf[ir[7:4]] = rf_wd;
    if (s.ACC_load) acc = r[7:0];
    if (s.FLAGS_load) dp_flags = '{z: (r[7:0] == 8'h00), n: r[7], c: r[8], v: 1'b0};
    pc = pc_n; ir = ir_n; reg_a = a_n; reg_b = b_n; mar = mar_n; mdr = mdr_n;
  endtask

  task automatic step();
    exp_t      e;
    ctrl_sig_t s;
    @(negedge clk);
    if (sbq.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_underflow: observed=empty expected=entry");
    end else begin
      e = sbq.pop_front();
      total++;
      assert (sigs === e.s) else begin
        bad++; $error("FAIL %s.sigs: observed=%h expected=%h", e.tag, sigs, e.s);
      end
      total++;
      assert (halted === e.h) else begin
        bad++; $error("FAIL %s.halted: observed=%b expected=%b", e.tag, halted, e.h);
      end
      total++;
      assert (illegal === e.il) else begin
        bad++; $error("FAIL %s.illegal: observed=%b expected=%b", e.tag, illegal, e.il);
      end
    end
    s = sigs;
    @(posedge clk);
    #1;
    dp_apply(s);
  endtask

  task automatic run();
    while (sbq.size() > 0) step();
  endtask

  task automatic exp_front(input string n, input logic il = 1'b0);
    ctrl_sig_t s;
    push({n, ".fetch_wait"}, '0);
    s = '0; s.IR_load = 1'b1; s.PC_write = 1'b1;
    push({n, ".fetch"}, s);
    s = '0; s.AB_load = 1'b1;
    push({n, ".decode"}, s, 1'b0, il);
  endtask

  task automatic exp_alu(input string n, input logic [2:0] op, input logic imm);
    ctrl_sig_t s;
    exp_front(n);
    s = '0; s.ALU_op = op; s.ALU_sel = imm; s.ACC_load = 1'b1; s.FLAGS_load = 1'b1;
    push({n, ".exec"}, s);
    s = '0; s.RF_write = 1'b1;
    push({n, ".wb"}, s);
  endtask

  task automatic exp_mem(input string n, input logic st);
    ctrl_sig_t s;
    exp_front(n);
    s = '0; s.MAR_load = 1'b1;
    push({n, ".addr"}, s);
    if (st) begin
      s = '0; s.AB_load = 1'b1; s.REG2_sel = 1'b1;
      push({n, ".st_data"}, s);
      s = '0; s.ALU_op = 3'd5; s.MEM_write = 1'b1;
      push({n, ".st_wr"}, s);
    end else begin
      s = '0; s.MDR_load = 1'b1;
      push({n, ".mem_rd"}, s);
      s = '0; s.RF_write = 1'b1; s.REGW_sel = 1'b1;
      push({n, ".mem_wb"}, s);
    end
  endtask

  task automatic exp_branch(input string n, input logic [1:0] asel, input logic psel,
                            input logic wr);
    ctrl_sig_t s;
    exp_front(n);
    s = '0; s.PC_write = wr; s.PC_sel = psel; s.ADDER_sel = asel;
    push({n, ".branch"}, s);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rf[1] = 8'h05; rf[2] = 8'h07;
    rf[8] = 8'h12; rf[9] = 8'h34; rf[10] = 8'h00; rf[11] = 8'h20;
    mem[16'h0507] = 8'hA5;
    rom[16'h0000] = 16'h1231;  // ADD r3,r1,r2
    rom[16'h0002] = 16'h1247;  // LD r4,[r1:r2]
    rom[16'h0004] = 16'h1238;  // ST r3,[r1:r2]
    rom[16'h0006] = 16'h1152;  // SUB r5,r1,r1 -> z=1
    rom[16'h0008] = 16'h006A;  // JMP +6
    rom[16'h0010] = 16'h0619;  // BR z,+6
    rom[16'h0018] = 16'h2166;  // ADDI r6 -> z=0
    rom[16'h001A] = 16'h0619;  // BR z,+6
    rom[16'h001C] = 16'h000D;  // reserved
    rom[16'h001E] = 16'h890B;  // JR r8:r9
    rom[16'h1234] = 16'h0000;  // NOP
    rom[16'h1236] = 16'hAB0B;  // JR r10:r11
    rom[16'h0020] = 16'hFFEA;  // JMP -2

    repeat (2) @(posedge clk);
    #1;
    check("reset.sigs", 32'(sigs), 32'h0);
    check("reset.halted", 32'(halted), 32'h0);
    check("reset.illegal", 32'(illegal), 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;

    exp_alu("add", 3'd0, 1'b0); run();
    check("add.r3", 32'(rf[3]), 32'h0C);
    check("add.pc", 32'(pc), 32'h0002);

    exp_mem("ld", 1'b0); run();
    check("ld.r4", 32'(rf[4]), 32'hA5);
    check("ld.pc", 32'(pc), 32'h0004);

    exp_mem("st", 1'b1); run();
    check("st.mem", 32'(mem_rd(16'h0507)), 32'h0C);
    check("st.r3_kept", 32'(rf[3]), 32'h0C);

    exp_alu("sub", 3'd1, 1'b0); run();
    check("sub.r5", 32'(rf[5]), 32'h00);
    check("sub.z", 32'(dp_flags.z), 32'h1);

    exp_branch("jmp_fwd", 2'd2, 1'b0, 1'b1); run();
    check("jmp_fwd.pc", 32'(pc), 32'h0010);

    exp_branch("br_taken", 2'd1, 1'b0, 1'b1); run();
    check("br_taken.pc", 32'(pc), 32'h0018);

    exp_alu("addi", 3'd0, 1'b1); run();
    check("addi.r6", 32'(rf[6]), 32'h09);

    exp_branch("br_not_taken", 2'd1, 1'b0, 1'b0); run();
    check("br_not_taken.pc", 32'(pc), 32'h001C);

    exp_front("reserved", 1'b1); run();
    check("reserved.pc", 32'(pc), 32'h001E);
    check("reserved.mem", 32'(mem_rd(16'h0507)), 32'h0C);

    exp_branch("jr", 2'd0, 1'b1, 1'b1); run();
    check("jr.pc", 32'(pc), 32'h1234);

    exp_front("nop"); run();
    check("nop.pc", 32'(pc), 32'h1236);

    exp_branch("jr_back", 2'd0, 1'b1, 1'b1); run();
    check("jr_back.pc", 32'(pc), 32'h0020);

    exp_branch("jmp_self", 2'd2, 1'b0, 1'b1); run();
    check("jmp_self.pc", 32'(pc), 32'h0020);

    rom[16'h0020] = 16'h000F;  // HALT
    exp_front("halt");
    for (int i = 0; i < 100; i++) push("halt.idle", '0, 1'b1, 1'b0);
    run();
    check("halt.pc", 32'(pc), 32'h0022);

    resetn = 1'b0;
    #1;
    check("rst_from_halt.halted", 32'(halted), 32'h0);
    repeat (2) @(posedge clk);
    pc = 16'h0000;
    rf[3] = 8'h77;
    @(posedge clk);
    #1 resetn = 1'b1;

    exp_front("add_abort"); run();
    #2 resetn = 1'b0;
    #1;
    check("abort.sigs", 32'(sigs), 32'h0);
    check("abort.halted", 32'(halted), 32'h0);
    check("abort.illegal", 32'(illegal), 32'h0);
    @(posedge clk);
    #1;
    check("abort.hold_sigs", 32'(sigs), 32'h0);
    pc = 16'h0000;
    @(posedge clk);
    #1 resetn = 1'b1;
    begin
      ctrl_sig_t s;
      push("restart.fetch_wait", '0);
      s = '0; s.IR_load = 1'b1; s.PC_write = 1'b1;
      push("restart.fetch", s);
    end
    run();
    check("abort.r3_kept", 32'(rf[3]), 32'h77);
    check("restart.pc", 32'(pc), 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the 8-bit/16-bit-instruction CPU. It decodes the latched instruction word and the registered ALU flags, and drives the datapath's `ctrl_sig_t` bundle state by state through fetch, decode, execute, memory and write-back. It sits beside `datapath` in the CPU top. It is the only source of every load, write and select strobe in the core.

## Interface
- `INSTR_WIDTH`, 16, instruction word width (fixed layout below).
- `ALU_OP_WIDTH`, 3, width of `sigs.ALU_op`.

- `clk`  in  1  single core clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `instruct`  in  16  IR contents. Opcode = `[3:0]`, rd/cond = `[7:4]`, rs2 = `[11:8]`, rs1 = `[15:12]`.
- `flags`  in  `alu_flags_t`  registered flags `{z,n,c,v}`.
- `sigs`  out  `ctrl_sig_t`  strobes, all 1 bit unless noted: PC_write, PC_sel, ADDER_sel[1:0], IR_load, AB_load, REG2_sel, RF_write, REGW_sel, ALU_sel, ALU_op[2:0], ACC_load, FLAGS_load, MAR_load, MDR_load, MEM_write.
- `halted`  out  1  high while in HALT.
- `illegal`  out  1  one-cycle pulse in DECODE on a reserved opcode.

## Operation
- Select encodings:
  - PC_sel: 0 = adder, 1 = {reg_a,reg_b}.
  - ADDER_sel: 0 = +2, 1 = sext(`[15:8]`), 2 = sext(`[15:4]`).
  - REG2_sel: 0 = `[11:8]`, 1 = `[7:4]`.
  - REGW_sel: 0 = ACC, 1 = MDR.
  - ALU_sel: 0 = reg_b, 1 = sext(`[15:12]`).
  - ALU_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASSB.
- Opcodes:
  - 0 NOP. 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (rd ← rs1 op rs2). 6 ADDI (rd ← rs1 + imm4).
  - 7 LD (rd ← M[{rs1,rs2}]). 8 ST (M[{rs1,rs2}] ← rd; uses REG2_sel=1 in a second read).
  - 9 BR cond, imm8. A JMP imm12. B JR {rs1,rs2}.
  - C–E reserved. F HALT.
- States and strobes (any strobe not listed is 0):
  - FETCH_WAIT: no strobes; ROM reads at PC. Next: FETCH.
  - FETCH: IR_load, PC_write, PC_sel=0, ADDER_sel=0, so PC += 2. Next: DECODE.
  - DECODE: AB_load, REG2_sel=0. Next by opcode: ALU ops and ADDI → EXEC; LD/ST → ADDR; BR/JMP/JR → BRANCH; F → HALT; 0 and reserved → FETCH_WAIT (`illegal` pulses for reserved).
  - EXEC: ALU_op per opcode, ALU_sel = (opcode==6), ACC_load, FLAGS_load. Next: WB.
  - WB: RF_write, REGW_sel=0. Next: FETCH_WAIT.
  - ADDR: MAR_load. LD → MEM_RD. ST → ST_DATA.
  - MEM_RD: MDR_load. Next: MEM_WB.
  - MEM_WB: RF_write, REGW_sel=1. Next: FETCH_WAIT.
  - ST_DATA: AB_load, REG2_sel=1. Next: ST_WR.
  - ST_WR: ALU_op=PASSB, MEM_write. Next: FETCH_WAIT.
  - BRANCH:
    - JMP: PC_write, ADDER_sel=2.
    - JR: PC_write, PC_sel=1.
    - BR: PC_write only if the condition holds, ADDER_sel=1. Cond `[7:4]`: 0 always, 1 z, 2 !z, 3 n, 4 c, 5 v, others never.
    - Next: FETCH_WAIT.
  - HALT: no strobes, `halted`=1. Stays until reset.
- Branch offsets are relative to the already-incremented PC (branch address + 2). Offsets are byte offsets.
- Flags are sampled in BRANCH from the `flags` input, i.e. the last FLAGS_load. Flags are never written by LD/ST/branches.

## Timing
- Reset (async assert, sync-safe deassert): state = FETCH_WAIT, `sigs` all 0, `halted`=0, `illegal`=0. Outputs clear immediately on reset assertion, mid-instruction included; a partially executed instruction has no further effect.
- All outputs are combinational from the state register and `instruct`/`flags` (Moore plus decode). Exactly one state per cycle.
- Cycles per instruction, FETCH_WAIT to the next FETCH_WAIT: NOP/reserved 3; ALU/ADDI 5; LD 6; ST 6; BR/JMP/JR 4; HALT terminal.
- PC_write and RF_write are never asserted in the same cycle. MEM_write asserts only in ST_WR.
- `instruct` is only decoded in DECODE and later states; IR is stable from the FETCH edge onward.

## Test plan
- Reset release, ROM `ADD r3,r1,r2` (0x1231) with r1=5, r2=7 → IR_load at cycle 2, WB at cycle 5, r3=12, PC=2, next FETCH_WAIT at cycle 6.
- `BR z,+6` with z=1 at PC=0x10 → PC=0x18 after BRANCH. Same with z=0 → PC=0x12, PC_write=0 in BRANCH.
- `LD r4,[r1:r2]` with M[0x0507]=0xA5 → MAR_load, MDR_load, RF_write on consecutive cycles; r4=0xA5; 6 cycles total.
- `JR` with r1=0x12, r2=0x34 → PC=0x1234. `JMP -2` (imm12=0xFFE) at PC=0x20 → PC=0x20.
- Opcode 0xD → `illegal` high for exactly one cycle, no RF/PC/MEM writes beyond the fetch increment.
- HALT → `halted`=1 indefinitely, no strobes for 100 cycles. Drop `resetn` mid-EXEC of ADD → `sigs`=0 immediately, no RF_write, restarts in FETCH_WAIT.
